// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the round-robin divider scheduler.
// Holds the default geometry, the scheduler state encoding and the
// divide-by-zero quotient pattern. Imported by div_arbiter and div_seq.
package div_arbiter_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // All-ones quotient reported for divide-by-zero; sliced to W bits at use.
    localparam logic [63:0] DBZ_Q = '1;

endpackage

// File: rtl/div_arbiter_div_seq.sv
// div_seq: W-bit unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset (control only)
//   start             load dividend/divisor and begin iterating
//   dividend, divisor operands, sampled on start
//   busy              iterating
//   done              combinational strobe: this cycle is the final step,
//                     q/r/dbz carry the final result
//   q, r              result of the current step (final when done)
//   dbz               the loaded divisor is zero
module div_seq
    import div_arbiter_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         dbz
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_p0;
    logic [W-1:0]  quo_p0;   // holds the dividend, shifted out MSB first as quotient bits shift in
    logic [W-1:0]  dvs_p0;
    logic [CW-1:0] cnt;
    logic [W:0]    diff;

    always_comb begin
        diff = {rem_p0, quo_p0[W-1]} - {1'b0, dvs_p0};
        dbz  = (dvs_p0 == '0);
        done = busy && (dbz || cnt == CW'(1));
        if (dbz) begin
            q = DBZ_Q[W-1:0];
            r = quo_p0;
        end else if (diff[W]) begin
            // Trial subtraction went negative: restore (keep shifted remainder).
            q = {quo_p0[W-2:0], 1'b0};
            r = {rem_p0[W-2:0], quo_p0[W-1]};
        end else begin
            q = {quo_p0[W-2:0], 1'b1};
            r = diff[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(W);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // ---- operand / iteration registers ----
    always_ff @(posedge clk) begin
        if (start) begin
            rem_p0 <= '0;
            quo_p0 <= dividend;
            dvs_p0 <= divisor;
        end else if (busy) begin
            rem_p0 <= r;
            quo_p0 <= q;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin scheduler sharing one iterative divider among
// N requesters.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req[N]     per-lane request, held until the matching gnt
//   x, y       packed dividends / divisors, lane i at [i*W +: W]
//   gnt[N]     one-hot pulse in the first RUN cycle of the granted lane
//   busy       division in progress (RUN or DONE)
//   done       one-cycle result strobe
//   done_id    lane whose result is on q/r
//   q, r, dbz  quotient, remainder, divide-by-zero flag (held until next done)
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       x,
    input  logic [N*W-1:0]       y,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] done_id,
    output logic [W-1:0]         q,
    output logic [W-1:0]         r,
    output logic                 dbz
);

    localparam int IDW = $clog2(N);

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cur_id;
    logic           found;
    logic           start;
    logic [W-1:0]   sel_x, sel_y;
    logic           seq_busy, seq_done, seq_dbz;
    logic [W-1:0]   seq_q, seq_r;

    // Round-robin search: first set req bit after ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        sel_x = x[win*W +: W];
        sel_y = y[win*W +: W];
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (seq_done) begin
                    state_nxt = ST_DONE;
                end else if (!seq_busy) begin
                    // Divider idle while we think it runs: recover.
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (found) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    div_seq #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (sel_x),
        .divisor  (sel_y),
        .busy     (seq_busy),
        .done     (seq_done),
        .q        (seq_q),
        .r        (seq_r),
        .dbz      (seq_dbz)
    );

    // ---- registered scheduler state and outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= IDW'(N - 1);
            cur_id  <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            q       <= '0;
            r       <= '0;
            dbz     <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            gnt   <= '0;
            done  <= 1'b0;
            if (start) begin
                ptr    <= win;
                cur_id <= win;
                gnt    <= N'(1) << win;
            end
            if (state == ST_RUN && seq_done) begin
                done    <= 1'b1;
                done_id <= cur_id;
                q       <= seq_q;
                r       <= seq_r;
                dbz     <= seq_dbz;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized
// request/operand mixes, checked against a behavioural model that uses
// plain division and the round-robin rule.
module tb_div_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] x, y;
    logic [N-1:0]   gnt;
    logic           busy, done, dbz;
    logic [1:0]     done_id;
    logic [W-1:0]   q, r;

    int total = 0;
    int bad   = 0;
    int mptr;
    int lane;
    int n;
    logic seen;

    always #5 clk = ~clk;

    div_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .x       (x),
        .y       (y),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .q       (q),
        .r       (r),
        .dbz     (dbz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int k = 1; k <= N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic load(input int i, input logic [W-1:0] xv, input logic [W-1:0] yv);
        x[i*W +: W] = xv;
        y[i*W +: W] = yv;
        req[i]      = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_id"}, 32'(done_id), 0);
        chk({tag, "_q"}, 32'(q), 0);
        chk({tag, "_r"}, 32'(r), 0);
        chk({tag, "_dbz"}, 32'(dbz), 0);
    endtask

    // Serve one pending request: expects gnt on the next cycle, then the
    // result after W cycles (1 for a zero divisor). Returns the lane.
    task automatic serve(output int lane_o);
        int w, c, lat;
        logic [W-1:0] xx, yy, eq, er;
        w = pick(req, mptr);
        if (w < 0) w = 0;
        c = 0;
        do begin step(); c++; end while (gnt == '0 && c < 40);
        chk("gnt_latency", c, 1);
        chk("gnt_onehot", 32'(gnt), 32'(1) << w);
        chk("busy_at_gnt", 32'(busy), 1);
        lane_o = w;
        mptr   = w;
        xx     = x[w*W +: W];
        yy     = y[w*W +: W];
        req[w] = 1'b0;
        lat    = (yy == 0) ? 1 : W;
        c = 0;
        do begin
            step();
            c++;
            if (c == 1) chk("gnt_pulse", 32'(gnt), 0);
        end while (!done && c < W + 8);
        chk("done_latency", c, lat);
        eq = (yy == 0) ? '1 : xx / yy;
        er = (yy == 0) ? xx : xx % yy;
        chk("q", 32'(q), 32'(eq));
        chk("r", 32'(r), 32'(er));
        chk("done_id", 32'(done_id), 32'(w));
        chk("dbz", 32'(dbz), (yy == 0) ? 1 : 0);
        chk("busy_at_done", 32'(busy), 1);
    endtask

    initial begin
        logic [3:0]   mask;
        logic [W-1:0] xv, yv;

        rst  = 1'b1;
        req  = '0;
        x    = '0;
        y    = '0;
        mptr = N - 1;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;

        // Single request 100/7
        load(0, 16'd100, 16'd7);
        serve(lane);
        chk("t1_lane", lane, 0);
        chk("t1_q", 32'(q), 14);
        chk("t1_r", 32'(r), 2);
        step();
        chk("t1_done_drop", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_q_hold", 32'(q), 14);

        // Round robin from a fresh reset: 0,1,2,3 back-to-back
        rst = 1'b1;
        step();
        rst  = 1'b0;
        mptr = N - 1;
        for (int i = 0; i < N; i++) load(i, 16'(1000 + 37 * i), 16'(3 + i));
        for (int k = 0; k < N; k++) begin
            serve(lane);
            chk("rr_order", lane, k);
        end

        // Wrap-around
        load(1, 16'd50, 16'd4);
        serve(lane);
        chk("wrap_a", lane, 1);
        load(3, 16'd77, 16'd5);
        load(1, 16'd88, 16'd6);
        serve(lane);
        chk("wrap_b", lane, 3);
        serve(lane);
        chk("wrap_c", lane, 1);
        load(3, 16'd12, 16'd5);
        serve(lane);
        chk("wrap_d", lane, 3);
        load(0, 16'd300, 16'd17);
        load(1, 16'd301, 16'd18);
        serve(lane);
        chk("wrap_e", lane, 0);
        serve(lane);
        chk("wrap_f", lane, 1);

        // Edge values
        load(2, 16'd65535, 16'd1);
        serve(lane);
        chk("edge1_q", 32'(q), 65535);
        load(2, 16'd5, 16'd9);
        serve(lane);
        chk("edge2_q", 32'(q), 0);
        chk("edge2_r", 32'(r), 5);
        load(2, 16'd65535, 16'd65535);
        serve(lane);
        chk("edge3_q", 32'(q), 1);
        chk("edge3_r", 32'(r), 0);

        // Divide by zero, then a normal op clears dbz
        load(0, 16'd1234, 16'd0);
        serve(lane);
        chk("dbz_q", 32'(q), 65535);
        chk("dbz_r", 32'(r), 1234);
        chk("dbz_flag", 32'(dbz), 1);
        load(0, 16'd9, 16'd3);
        serve(lane);
        chk("dbz_clr", 32'(dbz), 0);
        chk("dbz_next_q", 32'(q), 3);

        // A requester dropping before grant is skipped
        load(1, 16'd40, 16'd3);
        load(2, 16'd41, 16'd3);
        req[1] = 1'b0;
        serve(lane);
        chk("drop_skip", lane, 2);

        // Reset mid-operation
        load(1, 16'd1000, 16'd3);
        n = 0;
        do begin step(); n++; end while (gnt == '0 && n < 40);
        chk("mid_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst  = 1'b0;
        mptr = N - 1;
        chk_zero("mid_rst");
        seen = 1'b0;
        repeat (W + 4) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("mid_no_done", 32'(seen), 0);
        load(2, 16'd20, 16'd6);
        serve(lane);
        chk("mid_lane", lane, 2);
        chk("mid_q", 32'(q), 3);
        chk("mid_r", 32'(r), 2);

        // Randomized request mixes
        repeat (25) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    xv = W'($urandom);
                    case ($urandom_range(0, 7))
                        0:       yv = '0;
                        1:       yv = W'($urandom_range(1, 15));
                        2:       yv = xv;
                        default: yv = W'($urandom_range(1, 65535));
                    endcase
                    load(i, xv, yv);
                end
            end
            while (req != '0) serve(lane);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
